// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit scheduler.
// UART_TX_PARITY_EN adds the PARITY state to the FSM encoding.
package uart_pkg;

  localparam int unsigned DefDataW    = 8;
  localparam int unsigned DefStopBits = 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StStart,
    StData,
    StStop
  } uart_state_e;
`endif

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, on contention
// the requester named by pointer wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = pointer ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Two-requester UART transmitter with round-robin frame scheduling.
// Define UART_TX_PARITY_EN to append an even-parity bit to every frame.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned STOP_BITS = DefStopBits
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic [1:0]        req_valid,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  output logic [1:0]        req_ack,
  output logic              grant_id,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              prio_q, prio_d;
  logic              grant_id_q, grant_id_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        ack_q, ack_d;
  logic              tx_q, tx_d;
  logic [1:0]        grant;
  logic [DATA_W-1:0] sel_data;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // prio_q names the requester that wins a tie
  rr_arb2 u_arb (
    .req     (req_valid),
    .pointer (prio_q),
    .grant   (grant)
  );

  assign sel_data = grant[1] ? req_data1 : req_data0;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    prio_d     = prio_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ack_d      = 2'b00;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      StIdle: begin
        if (|req_valid) begin
          ack_d      = grant;
          grant_id_d = grant[1];
          prio_d     = ~grant[1];
          shreg_d    = sel_data;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = StAlign;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^sel_data;
`endif
        end
      end
      // wait for a fresh tick so the start bit is a full period
      StAlign: if (baud_tick) state_d = StStart;
      StStart: if (baud_tick) state_d = StData;
      StData: begin
        if (baud_tick) begin
          if (bit_cnt_q == CntW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: if (baud_tick) state_d = StStop;
`endif
      StStop: begin
        if (baud_tick) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // line level follows the state being entered, keeping tx registered
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      prio_q     <= 1'b0;
      grant_id_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_q      <= 2'b00;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      prio_q     <= prio_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign req_ack  = ack_q;
  assign grant_id = grant_id_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: randomized frames against a
// bit-list reference model; honours UART_TX_PARITY_EN.
module tb_uart_tx_scheduler;

  localparam int DW = 8;
  localparam int SB = 1;

  logic          clk;
  logic          rst;
  logic          baud_tick;
  logic [1:0]    req_valid;
  logic [DW-1:0] req_data0;
  logic [DW-1:0] req_data1;
  logic [1:0]    req_ack;
  logic          grant_id;
  logic          tx;
  logic          busy;
  logic          done;

  uart_tx_scheduler #(
    .DATA_W    (DW),
    .STOP_BITS (SB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ack   (req_ack),
    .grant_id  (grant_id),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt;
  int ack_cnt;
  bit persist [2];
  logic tx_bits[$];
  logic exp_bits[$];
  int ack_ids[$];
  logic ack_gid[$];
  logic [DW-1:0] hist0[$];
  logic [DW-1:0] hist1[$];

  // Expected line levels sampled once per bit period: align, start, data LSB first,
  // optional even parity, stop bits.
  function automatic void push_frame(input logic [DW-1:0] d);
    exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    exp_bits.push_back(^d);
`endif
    for (int i = 0; i < SB; i++) exp_bits.push_back(1'b1);
  endfunction

  // One clock: drive the tick for the coming edge and log what the line shows now.
  task automatic step(input bit t);
    @(negedge clk);
    baud_tick = t;
    if (t && busy) tx_bits.push_back(tx);
    if (done) done_cnt++;
    for (int i = 0; i < 2; i++) begin
      if (req_ack[i]) begin
        ack_cnt++;
        ack_ids.push_back(i);
        ack_gid.push_back(grant_id);
        if (persist[i]) begin
          if (i == 0) begin
            req_data0 = DW'($urandom);
            hist0.push_back(req_data0);
          end else begin
            req_data1 = DW'($urandom);
            hist1.push_back(req_data1);
          end
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic run_until(input int nframes, input int period, input int budget);
    int k = 0;
    while (done_cnt < nframes && k < budget) begin
      if (period == 0) step($urandom_range(0, 2) == 0);
      else step((k % period) == period - 1);
      k++;
    end
    checks++;
    if (done_cnt < nframes) begin
      errors++;
      $display("FAIL frame_timeout got done=%0d want %0d", done_cnt, nframes);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    baud_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    ack_cnt = 0;
    persist[0] = 1'b0;
    persist[1] = 1'b0;
    tx_bits.delete();
    exp_bits.delete();
    ack_ids.delete();
    ack_gid.delete();
    hist0.delete();
    hist1.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    baud_tick = 1'b0;
    req_data0 = DW'($urandom);
    req_data1 = DW'($urandom);
    repeat (2) @(negedge clk);
    checks += 5;
    if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx got %b want 1", tx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    if (req_ack !== 2'b00) begin errors++; $display("FAIL rst_ack got %b want 00", req_ack); end
    if (grant_id !== 1'b0) begin errors++; $display("FAIL rst_gid got %b want 0", grant_id); end
    rst = 1'b0;
    done_cnt = 0;
    ack_cnt = 0;
    repeat (4) step(1'b1);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1 || ack_cnt != 0) begin
      errors++;
      $display("FAIL idle_no_req got busy=%b tx=%b acks=%0d want 0 1 0", busy, tx, ack_cnt);
    end
  endtask

  task automatic test_single_a5();
    do_reset();
    req_data0 = 8'hA5;
    req_valid = 2'b01;
    push_frame(8'hA5);
    run_until(1, 10, 400);
    step(1'b0);
    checks++;
    if (tx_bits.size() != exp_bits.size()) begin
      errors++;
      $display("FAIL a5_len got %0d want %0d", tx_bits.size(), exp_bits.size());
    end else begin
      for (int i = 0; i < exp_bits.size(); i++) begin
        checks++;
        if (tx_bits[i] !== exp_bits[i]) begin
          errors++;
          $display("FAIL a5_bit[%0d] got %b want %b", i, tx_bits[i], exp_bits[i]);
        end
      end
    end
    checks += 3;
    if (ack_cnt != 1 || ack_ids[0] != 0) begin
      errors++;
      $display("FAIL a5_ack got count=%0d want 1 on requester 0", ack_cnt);
    end
    if (done_cnt != 1) begin errors++; $display("FAIL a5_done got %0d want 1", done_cnt); end
    if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy_end got %b want 0", busy); end
  endtask

  task automatic test_both();
    do_reset();
    req_data0 = 8'h11;
    req_data1 = 8'h22;
    req_valid = 2'b11;
    push_frame(8'h11);
    push_frame(8'h22);
    run_until(2, 6, 800);
    checks++;
    if (tx_bits.size() != exp_bits.size()) begin
      errors++;
      $display("FAIL both_len got %0d want %0d", tx_bits.size(), exp_bits.size());
    end else begin
      for (int i = 0; i < exp_bits.size(); i++) begin
        checks++;
        if (tx_bits[i] !== exp_bits[i]) begin
          errors++;
          $display("FAIL both_bit[%0d] got %b want %b", i, tx_bits[i], exp_bits[i]);
        end
      end
    end
    checks++;
    if (ack_ids.size() != 2) begin
      errors++;
      $display("FAIL both_acks got %0d want 2", ack_ids.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ack_ids[i] != i || ack_gid[i] !== 1'(i)) begin
          errors++;
          $display("FAIL both_order[%0d] got ack=%0d gid=%b want %0d", i, ack_ids[i], ack_gid[i], i);
        end
      end
    end
  endtask

  task automatic test_alternate();
    int n0 = 0;
    int n1 = 0;
    do_reset();
    persist[0] = 1'b1;
    persist[1] = 1'b1;
    req_data0 = DW'($urandom);
    req_data1 = DW'($urandom);
    hist0.push_back(req_data0);
    hist1.push_back(req_data1);
    req_valid = 2'b11;
    run_until(4, 5, 2000);
    req_valid = 2'b00;
    for (int f = 0; f < 4; f++) begin
      if (f % 2 == 0) push_frame(hist0[n0++]);
      else push_frame(hist1[n1++]);
    end
    for (int f = 0; f < 4; f++) begin
      checks++;
      if (f >= ack_ids.size() || ack_ids[f] != f % 2) begin
        errors++;
        $display("FAIL alt_grant[%0d] got %0d want %0d", f,
                 (f < ack_ids.size()) ? ack_ids[f] : -1, f % 2);
      end
    end
    checks++;
    if (tx_bits.size() != exp_bits.size()) begin
      errors++;
      $display("FAIL alt_len got %0d want %0d", tx_bits.size(), exp_bits.size());
    end else begin
      for (int i = 0; i < exp_bits.size(); i++) begin
        checks++;
        if (tx_bits[i] !== exp_bits[i]) begin
          errors++;
          $display("FAIL alt_bit[%0d] got %b want %b", i, tx_bits[i], exp_bits[i]);
        end
      end
    end
    repeat (3) step(1'b0);
  endtask

  task automatic test_random();
    int exp_ids[$];
    logic prio = 1'b0;
    int target = 0;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      logic [1:0] mask;
      logic [1:0] pend;
      logic [DW-1:0] dv [2];
      mask = 2'($urandom_range(1, 3));
      dv[0] = DW'($urandom);
      dv[1] = DW'($urandom);
      req_data0 = dv[0];
      req_data1 = dv[1];
      pend = mask;
      while (pend != 2'b00) begin
        int g;
        g = (pend == 2'b11) ? int'(prio) : (pend[0] ? 0 : 1);
        exp_ids.push_back(g);
        push_frame(dv[g]);
        prio = (g == 0);
        pend[g] = 1'b0;
        target++;
      end
      req_valid = mask;
      run_until(target, 0, 3000);
    end
    checks++;
    if (ack_ids.size() != exp_ids.size()) begin
      errors++;
      $display("FAIL rnd_acks got %0d want %0d", ack_ids.size(), exp_ids.size());
    end else begin
      for (int i = 0; i < exp_ids.size(); i++) begin
        checks++;
        if (ack_ids[i] != exp_ids[i] || ack_gid[i] !== 1'(exp_ids[i])) begin
          errors++;
          $display("FAIL rnd_grant[%0d] got %0d want %0d", i, ack_ids[i], exp_ids[i]);
        end
      end
    end
    checks++;
    if (tx_bits.size() != exp_bits.size()) begin
      errors++;
      $display("FAIL rnd_len got %0d want %0d", tx_bits.size(), exp_bits.size());
    end else begin
      for (int i = 0; i < exp_bits.size(); i++) begin
        checks++;
        if (tx_bits[i] !== exp_bits[i]) begin
          errors++;
          $display("FAIL rnd_bit[%0d] got %b want %b", i, tx_bits[i], exp_bits[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    do_reset();
    req_data1 = DW'($urandom);
    req_valid = 2'b10;
    // align, start, d0..d2 logged means data bit 3 follows the next edge
    while (tx_bits.size() < 5 && k < 200) begin
      step((k % 4) == 3);
      k++;
    end
    step(1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got tx=%b busy=%b done=%b want 1 0 0", tx, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 40; j++) step((j % 4) == 3);
    checks++;
    if (done_cnt != 0 || ack_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_after got done=%0d acks=%0d busy=%b want 0 1 0", done_cnt, ack_cnt, busy);
    end
    req_data0 = DW'($urandom);
    req_data1 = DW'($urandom);
    req_valid = 2'b11;
    run_until(2, 4, 800);
    checks++;
    if (ack_ids.size() < 2 || ack_ids[1] != 0 || ack_gid[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_prio got %0d want 0", (ack_ids.size() > 1) ? ack_ids[1] : -1);
    end
  endtask

  task automatic test_align_hold();
    int k = 1;
    int zeros = 0;
    bit held = 1'b0;
    logic tv;
    bit stable;
    do_reset();
    req_data0 = 8'hFF;
    req_valid = 2'b01;
    push_frame(8'hFF);
    step(1'b1);
    while (done_cnt < 1 && k < 800) begin
      if (!held && tx_bits.size() == 4) begin
        held = 1'b1;
        step(1'b0);
        tv = tx;
        stable = 1'b1;
        repeat (40) begin
          step(1'b0);
          if (tx !== tv || busy !== 1'b1) stable = 1'b0;
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL hold got tx/busy change want stable"); end
      end
      step((k % 6) == 0);
      if (busy === 1'b1 && tx === 1'b0) zeros++;
      k++;
    end
    checks++;
    if (zeros != 6) begin errors++; $display("FAIL align_start_width got %0d want 6", zeros); end
    checks++;
    if (tx_bits.size() != exp_bits.size()) begin
      errors++;
      $display("FAIL align_len got %0d want %0d", tx_bits.size(), exp_bits.size());
    end else begin
      for (int i = 0; i < exp_bits.size(); i++) begin
        checks++;
        if (tx_bits[i] !== exp_bits[i]) begin
          errors++;
          $display("FAIL align_bit[%0d] got %b want %b", i, tx_bits[i], exp_bits[i]);
        end
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    do_reset();
    req_data0 = 8'h07;
    req_valid = 2'b01;
    run_until(1, 5, 400);
    checks++;
    if (tx_bits.size() != 12 || tx_bits[10] !== 1'b1) begin
      errors++;
      $display("FAIL par_07 got len=%0d want len=12 parity=1", tx_bits.size());
    end
    tx_bits.delete();
    req_data0 = 8'h03;
    req_valid = 2'b01;
    run_until(2, 5, 400);
    checks++;
    if (tx_bits.size() != 12 || tx_bits[10] !== 1'b0) begin
      errors++;
      $display("FAIL par_03 got len=%0d want len=12 parity=0", tx_bits.size());
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    baud_tick = 1'b0;
    req_valid = 2'b00;
    req_data0 = '0;
    req_data1 = '0;
    test_reset();
    test_single_a5();
    test_both();
    test_alternate();
    test_random();
    test_reset_mid();
    test_align_hold();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame.
REQ-002 Parameter STOP_BITS, default 1, stop bits per frame (legal 1..2).
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 baud_tick  input  1  one-cycle pulse per bit period from the baud generator.
REQ-006 req_valid  input  2  per-requester transmit request, held until acknowledged.
REQ-007 req_data0  input  DATA_W  requester 0 payload.
REQ-008 req_data1  input  DATA_W  requester 1 payload.
REQ-009 req_ack  output  2  one-hot, one-cycle pulse when that requester's data is latched.
REQ-010 grant_id  output  1  index of the requester owning the current frame.
REQ-011 tx  output  1  serial line, idle high.
REQ-012 busy  output  1  high from latch cycle until frame end.
REQ-013 done  output  1  one-cycle pulse on the final stop-bit tick.

Function
REQ-014 The FSM SHALL have states IDLE, ALIGN, START, DATA, PARITY, STOP.
REQ-015 In IDLE with any req_valid bit set, the block SHALL latch the winner's data into a shift register, pulse req_ack[winner], set grant_id and busy, and enter ALIGN in the same cycle.
REQ-016 Arbitration SHALL be round-robin: single requester wins; on both valid, the requester not granted last wins; after reset requester 0 has priority.
REQ-017 ALIGN SHALL drive tx=1 and move to START on the next baud_tick, so the start bit is tick-aligned even if baud_tick coincides with the latch cycle.
REQ-018 START SHALL drive tx=0 for one bit period, then enter DATA on baud_tick.
REQ-019 DATA SHALL drive bits LSB first, advancing one bit per baud_tick, for exactly DATA_W periods.
REQ-020 After the last data bit, the FSM SHALL enter PARITY when parity is compiled in, else STOP.
REQ-021 STOP SHALL drive tx=1 for STOP_BITS periods; on the final tick it SHALL pulse done, clear busy and return to IDLE.
REQ-022 A request present when done pulses SHALL be evaluated in the following IDLE cycle; minimum frame-to-frame gap is one clk plus ALIGN.
REQ-023 req_valid changes while busy SHALL be ignored; req_data SHALL be sampled only in the latch cycle.
REQ-024 The bit counter SHALL be $clog2(DATA_W+1) bits wide and SHALL never wrap within a frame.
REQ-025 Without baud_tick, the FSM SHALL hold state and tx indefinitely.
REQ-026 tx SHALL be registered, with no combinational path from inputs.

Reset
REQ-027 On rst: state=IDLE, tx=1, busy=0, done=0, req_ack=0, grant_id=0, round-robin pointer favours requester 0, shift register and counters=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 asynchronously) with no done pulse; the aborted requester SHALL NOT be re-acknowledged.

Configuration
REQ-029 Macro UART_TX_PARITY_EN: when defined, the PARITY state SHALL drive even parity (XOR of data bits) for one bit period.
REQ-030 Without UART_TX_PARITY_EN, the PARITY state and parity logic SHALL be absent and frames SHALL be 1+DATA_W+STOP_BITS bits.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state enum and the default DATA_W/STOP_BITS constants.
REQ-032 The round-robin logic SHALL be a sub-module rr_arb2 (inputs req[1:0], pointer; outputs one-hot grant).

Verification
REQ-033 req_valid=01, data0=0xA5, tick every 10 clk -> tx: 0,1,0,1,0,0,1,0,1,1 per period; one ack[0]; done once.
REQ-034 Both valid from reset, data0=0x11, data1=0x22 -> frame 0x11 (grant_id=0), then 0x22 (grant_id=1); acks in that order.
REQ-035 Requester 0 re-requests continuously alongside requester 1 -> grants alternate 0,1,0,1 over four frames.
REQ-036 With UART_TX_PARITY_EN, data 0x07 -> parity bit 1; data 0x03 -> parity bit 0; frame 11 periods.
REQ-037 rst asserted during data bit 3 -> tx=1, busy=0 same cycle; no done; next request starts from IDLE with requester 0 priority.
REQ-038 baud_tick coincident with latch cycle -> start bit begins on the following tick, full-width.
